// File: rtl/mpu_pkg.sv
// -----------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the MPU result reader: matrix geometry, the reader
// state enum and the element bit-offset helper used to unpack the flattened
// 5x5 int8 matrix (element (r,c) lives at bits at(r,c) +: ELEM_W).
// -----------------------------------------------------------------------------
package mpu_pkg;

    localparam int MATRIX_DIM = 5;
    localparam int ELEM_W     = 8;
    localparam int NUM_ELEMS  = MATRIX_DIM * MATRIX_DIM;
    localparam int MATRIX_W   = NUM_ELEMS * ELEM_W;   // 200
    localparam int IDX_W      = 3;                    // row/col index width
    localparam int SEL_W      = $clog2(NUM_ELEMS);    // flat element index width
    localparam int OFF_W      = $clog2(MATRIX_W);     // bit offset width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bit offset of element (r,c) inside the flattened matrix.
    function automatic logic [OFF_W-1:0] at(input logic [IDX_W-1:0] r,
                                            input logic [IDX_W-1:0] c);
        return OFF_W'(ELEM_W * (int'(c) + MATRIX_DIM * int'(r)));
    endfunction

endpackage

// File: rtl/mpu_result_reader_if.sv
// -----------------------------------------------------------------------------
// mpu_result_reader_if
// Valid/ready element stream leaving the result reader.
//   out_valid : element fields below are valid
//   out_ready : consumer accepts the element (transfer when both high)
//   out_data  : signed int8 element
//   out_row   : output-matrix row of out_data (0..4)
//   out_col   : output-matrix column of out_data (0..4)
//   out_last  : element at position (4,4)
// master = producer (reader), slave = consumer.
// -----------------------------------------------------------------------------
interface mpu_result_reader_if;
    import mpu_pkg::*;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [ELEM_W-1:0] out_data;
    logic [IDX_W-1:0]         out_row;
    logic [IDX_W-1:0]         out_col;
    logic                     out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/mpu_index_counter.sv
// -----------------------------------------------------------------------------
// mpu_index_counter
// Row-major 5x5 position counter. col advances on every 'advance'; after col 4
// it wraps to 0 and row advances. 'clear' returns to (0,0) and wins over
// 'advance'. 'last' flags position (4,4).
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   clear          : synchronous return to (0,0)
//   advance        : step to the next position
//   row, col       : current position
//   last           : current position is (4,4)
// -----------------------------------------------------------------------------
module mpu_index_counter
    import mpu_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_DIM - 1);

    logic [IDX_W-1:0] row_reg, row_next;
    logic [IDX_W-1:0] col_reg, col_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (clear) begin
            row_next = '0;
            col_next = '0;
        end else if (advance) begin
            if (col_reg == LAST_IDX) begin
                col_next = '0;
                row_next = (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

endmodule

// File: rtl/mpu_result_reader.sv
// -----------------------------------------------------------------------------
// mpu_result_reader
// Captures a flattened 5x5 signed int8 matrix on 'start' and streams its 25
// elements (optionally transposed) in row-major output order over a
// valid/ready interface, then pulses 'done' for one cycle.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   start          : capture request, honoured only in IDLE
//   transpose      : sampled with start; 1 streams the transpose
//   matrix         : flattened matrix, element (r,c) at bits at(r,c) +: 8
//   result         : element stream (master side)
//   busy           : high in STREAM and DONE
//   done           : one-cycle pulse after the last transfer
// -----------------------------------------------------------------------------
module mpu_result_reader
    import mpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                transpose,
    input  logic [MATRIX_W-1:0] matrix,
    mpu_result_reader_if.master result,
    output logic                busy,
    output logic                done
);

    state_t state_reg, state_next;

    logic [MATRIX_W-1:0]      shadow_reg;
    logic                     transpose_reg;
    logic                     capture;
    logic                     advance;
    logic                     streaming;
    logic [IDX_W-1:0]         row;
    logic [IDX_W-1:0]         col;
    logic                     at_last;
    logic [SEL_W-1:0]         sel_idx;
    logic signed [ELEM_W-1:0] elem [NUM_ELEMS];

    // Position counter: cleared on capture, stepped on every transfer.
    mpu_index_counter u_index (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (capture),
        .advance (advance),
        .row     (row),
        .col     (col),
        .last    (at_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (result.out_ready) begin
                    advance = 1'b1;
                    if (at_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Private copy of the matrix so the source may change during streaming.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_reg    <= '0;
            transpose_reg <= 1'b0;
        end else if (capture) begin
            shadow_reg    <= matrix;
            transpose_reg <= transpose;
        end
    end

    // Unpack the shadow into a flat element array indexed by r*5+c.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_elem
            assign elem[gi] = shadow_reg[at(IDX_W'(gi / MATRIX_DIM),
                                            IDX_W'(gi % MATRIX_DIM)) +: ELEM_W];
        end
    endgenerate

    // Transposed output swaps the roles of output row and column.
    assign sel_idx = transpose_reg
                   ? SEL_W'(int'(col) * MATRIX_DIM + int'(row))
                   : SEL_W'(int'(row) * MATRIX_DIM + int'(col));

    assign streaming = (state_reg == STREAM);

    // Element fields read as zero whenever no element is on offer.
    assign result.out_valid = streaming;
    assign result.out_last  = streaming && at_last;
    assign result.out_row   = streaming ? row : '0;
    assign result.out_col   = streaming ? col : '0;
    assign result.out_data  = streaming ? elem[sel_idx] : '0;

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_mpu_result_reader.sv
module tb_mpu_result_reader;
    import mpu_pkg::*;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                transpose = 1'b0;
    logic [MATRIX_W-1:0] matrix = '0;
    logic                busy;
    logic                done;

    mpu_result_reader_if sif();

    mpu_result_reader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .transpose (transpose),
        .matrix    (matrix),
        .result    (sif),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    int mat [5][5];     // matrix presented on the input bus
    int cap [5][5];     // reference copy taken at start

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MATRIX_W-1:0] pack_mat();
        logic [MATRIX_W-1:0] p;
        logic [7:0]          b;
        p = '0;
        for (int k = NUM_ELEMS - 1; k >= 0; k--) begin
            b = 8'(mat[k / 5][k % 5]);
            p = {p[MATRIX_W-9:0], b};
        end
        return p;
    endfunction

    // Elements 1..25 filled down the columns: (r,c) = 5c + r + 1.
    task automatic fill_seq();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mat[r][c] = 5 * c + r + 1;
    endtask

    task automatic fill_neg_identity();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mat[r][c] = (r == c) ? -1 : 0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                mat[r][c] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(sif.out_valid), 32'd0);
        check({tag, "_last"},  32'(sif.out_last),  32'd0);
        check({tag, "_busy"},  32'(busy),          32'd0);
        check({tag, "_done"},  32'(done),          32'd0);
        check({tag, "_data"},  32'(sif.out_data),  32'd0);
        check({tag, "_row"},   32'(sif.out_row),   32'd0);
        check({tag, "_col"},   32'(sif.out_col),   32'd0);
    endtask

    // One full (or aborted) stream. ready_mode: 0 always, 1 toggle 1/0, 2 random.
    task automatic run_stream(input int tr, input int ready_mode, input int abort_at,
                              input bit mid_start, output int valid_cycles);
        int  idx;
        int  cyc;
        int  r;
        int  c;
        int  exp_val;
        bit  rdy;
        bit  tog;
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);
        matrix    = pack_mat();
        transpose = tr[0];
        start     = 1'b1;
        cap       = mat;
        sif.out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        idx = 0;
        cyc = 0;
        tog = 1'b1;
        valid_cycles = 0;
        while (idx < NUM_ELEMS && cyc < 300) begin
            r = idx / 5;
            c = idx % 5;
            exp_val = (tr != 0) ? cap[c][r] : cap[r][c];
            check("valid", 32'(sif.out_valid), 32'd1);
            check("data",  32'(sif.out_data),  32'(exp_val));
            check("row",   32'(sif.out_row),   32'(r));
            check("col",   32'(sif.out_col),   32'(c));
            check("last",  32'(sif.out_last),  32'(r == 4 && c == 4));
            check("busy",  32'(busy),          32'd1);
            check("done_early", 32'(done),     32'd0);
            valid_cycles++;
            if (mid_start && cyc == 4) begin
                fill_random();
                matrix    = pack_mat();
                transpose = ~tr[0];
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            sif.out_ready = rdy;
            if (rdy) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                @(negedge clock);
                sif.out_ready = 1'b0;
                check("pre_abort_done", 32'(done), 32'd0);
                reset_n = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clock);
                reset_n = 1'b1;
                repeat (3) begin
                    @(negedge clock);
                    check("post_abort_busy", 32'(busy), 32'd0);
                    check("post_abort_done", 32'(done), 32'd0);
                end
                $display("stream aborted after %0d transfers", idx);
                return;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("timeout", 32'(idx), 32'(NUM_ELEMS));
        sif.out_ready = 1'b0;
        check("done_pulse",  32'(done),          32'd1);
        check("done_busy",   32'(busy),          32'd1);
        check("done_valid",  32'(sif.out_valid), 32'd0);
        @(negedge clock);
        check("done_clear",  32'(done),          32'd0);
        check("idle_again",  32'(busy),          32'd0);
        $display("stream tr=%0d ready_mode=%0d transfers=%0d valid_cycles=%0d",
                 tr, ready_mode, idx, valid_cycles);
    endtask

    int ncyc;

    initial begin
        sif.out_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Sequential matrix, straight and always ready: 25 back-to-back transfers.
        fill_seq();
        run_stream(0, 0, -1, 1'b0, ncyc);
        check("cycles_ready", 32'(ncyc), 32'd25);

        // Transposed readout of the same matrix.
        run_stream(1, 0, -1, 1'b0, ncyc);

        // Alternating ready: 49 cycles from first valid to last transfer.
        run_stream(0, 1, -1, 1'b0, ncyc);
        check("cycles_toggle", 32'(ncyc), 32'd49);

        // Start pulsed mid-stream with a new matrix and transpose must be ignored.
        fill_seq();
        run_stream(0, 2, -1, 1'b1, ncyc);

        // Reset after 10 transfers, then a fresh stream from (0,0).
        fill_seq();
        run_stream(0, 0, 10, 1'b0, ncyc);
        run_stream(0, 0, -1, 1'b0, ncyc);

        // Signed negative identity, both orientations.
        fill_neg_identity();
        run_stream(0, 2, -1, 1'b0, ncyc);
        run_stream(1, 0, -1, 1'b0, ncyc);

        // Random matrices, random orientation and backpressure.
        for (int t = 0; t < 4; t++) begin
            fill_random();
            run_stream(int'($urandom_range(0, 1)), 2, -1, 1'b0, ncyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_result_reader.md
MPU_RESULT_READER -- requirements
Module: mpu_result_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clock and reset_n.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to capture matrix and begin streaming; acted on only in IDLE.
REQ-005 transpose  input  1  sampled with start; 1 streams the transpose of the captured matrix.
REQ-006 matrix  input  200  signed flattened 5x5 int8 matrix; element (r,c) at bits 8*(c+5*r) +: 8.
REQ-007 out_valid  output  1  out_data/out_row/out_col/out_last hold a valid element.
REQ-008 out_ready  input  1  consumer accepts the element; a transfer occurs when out_valid and out_ready are both 1.
REQ-009 out_data  output  8  signed element being offered.
REQ-010 out_row, out_col  output  3 each  output-matrix position of out_data, range 0..4.
REQ-011 out_last  output  1  high with the element at position (4,4).
REQ-012 busy  output  1  high in STREAM and DONE.
REQ-013 done  output  1  one-cycle pulse after the last transfer.

Function
REQ-014 The block SHALL implement states IDLE, STREAM, DONE.
REQ-015 IDLE with start=1: register matrix into a 200-bit shadow register, register transpose, clear row/col to 0, and go to STREAM.
REQ-016 out_valid SHALL rise on the cycle after start is sampled (1-cycle latency) and stay high throughout STREAM.
REQ-017 out_data SHALL be shadow(out_row,out_col) when transpose=0, and shadow(out_col,out_row) when transpose=1.
REQ-018 Order SHALL be row-major on output position: on each transfer col increments; when col=4 it wraps to 0 and row increments.
REQ-019 With out_valid=1 and out_ready=0, every output SHALL hold its value (no data change, no index advance).
REQ-020 out_last SHALL be 1 only when row=4 and col=4 in STREAM.
REQ-021 The transfer with out_last=1 SHALL move the block to DONE; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 start SHALL be ignored in STREAM and DONE; the earliest new capture is the cycle after DONE.
REQ-023 Changes on matrix or transpose after capture SHALL NOT affect the stream in progress.
REQ-024 Exactly 25 transfers SHALL occur per start; elements pass through unmodified (no width change or sign change).

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, and out_valid, out_last, busy, done, out_data, out_row, out_col and the shadow register to 0.
REQ-026 Reset asserted mid-stream SHALL abort the stream without a done pulse; after release the block waits in IDLE for a new start.

Structure
REQ-027 A shared package mpu_pkg SHALL hold MATRIX_DIM=5, ELEM_W=8, MATRIX_W=200, the state enum, and the element-offset function at(r,c)=8*(c+5*r).
REQ-028 The row/col wrap counter SHALL be a sub-module named mpu_index_counter, with inputs clear and advance and outputs row, col and last.

Verification
REQ-029 Capture the 5x5 matrix with elements 1..25, transpose=0, out_ready always 1 -> 25 consecutive transfers; (0,0)=1, (0,4)=21, (4,4)=25 with out_last=1; done pulses one cycle after the last transfer.
REQ-030 Same matrix with transpose=1 -> position (0,1) carries 2 and (1,0) carries 6.
REQ-031 Toggle out_ready 0/1 each cycle -> outputs hold while out_ready=0, and the stream takes 49 cycles from first valid to last transfer.
REQ-032 Pulse start during STREAM with a different matrix -> ignored; the stream finishes with the original data.
REQ-033 Assert reset_n=0 after 10 transfers -> all outputs go to 0 at once, with no done pulse; a new start then streams from (0,0).
REQ-034 Signed identity matrix scaled by -1 -> diagonal elements read out as -1, all other elements 0.
